// File: rtl/loader_pkg.sv
// Shared types and constants for the UART boot loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0]  DEF_SYNC    = 8'hA5;
  localparam int unsigned CLK_HZ      = 100_000_000;
  localparam int unsigned BAUD        = 9600;
  localparam int unsigned BIT_CYCLES  = CLK_HZ / BAUD;
  localparam int unsigned TIMEOUT_CYC = 100 * BIT_CYCLES;

  // States in which a packet is being received
  function automatic logic is_busy(input state_t s);
    return (s == LEN) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// Idle counter between received bytes; flags expiry when the count hits LIMIT.
module byte_timeout #(
  parameter int unsigned LIMIT = 1_041_600
) (
  input  logic clk,
  input  logic clr,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_expired_c = (r_cnt == CNT_W'(LIMIT));

  // Saturates at LIMIT so expiry stays asserted until the owner reacts
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired_c) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Frames rx bytes as sync/length/payload/checksum, writes the payload to memory
// and releases the CPU only after a packet with a good checksum.
module uart_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter logic [7:0]  SYNC    = DEF_SYNC,
  parameter int unsigned TIMEOUT = TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              err
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ready_q;
  logic              w_strobe;
  logic              w_expired;
  logic              w_wr;
  logic              w_len_ld;
  logic              w_last;
  logic [7:0]        r_len;
  logic [7:0]        r_sum;
  logic [7:0]        r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic              r_mem_we;
  logic [7:0]        r_mem_wdata;
  logic              r_cpu_run;
  logic              r_busy;
  logic              r_err;

  assign w_strobe = rx_ready & ~r_ready_q;
  assign w_last   = ((r_idx + 8'd1) == r_len);

  byte_timeout #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk        (clk),
    .clr        (clr),
    .i_clear    (w_strobe | (w_state_nxt != r_state)),
    .i_enable   (is_busy(r_state)),
    .o_expired_c(w_expired)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Timeout has priority over a byte arriving in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_len_ld    = 1'b0;
    if (w_expired && is_busy(r_state)) begin
      w_state_nxt = ERR;
    end else if (w_strobe) begin
      case (r_state)
        IDLE, DONE, ERR: begin
          if (rx_data == SYNC) w_state_nxt = LEN;
        end
        LEN: begin
          w_len_ld    = 1'b1;
          w_state_nxt = (rx_data != 8'd0) ? DATA : CSUM;
        end
        DATA: begin
          w_wr = 1'b1;
          if (w_last) w_state_nxt = CSUM;
        end
        CSUM: begin
          w_state_nxt = (rx_data == r_sum) ? DONE : ERR;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Address advances the cycle after the write strobe so the write sees the old value
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_ready_q   <= 1'b0;
      r_len       <= 8'd0;
      r_sum       <= 8'd0;
      r_idx       <= 8'd0;
      r_addr      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 8'd0;
      r_cpu_run   <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ready_q <= rx_ready;
      r_mem_we  <= w_wr;
      if (w_wr) r_mem_wdata <= rx_data;
      if (w_len_ld) begin
        r_len  <= rx_data;
        r_sum  <= 8'd0;
        r_idx  <= 8'd0;
        r_addr <= '0;
      end else begin
        if (w_wr) begin
          r_sum <= r_sum + rx_data;
          r_idx <= r_idx + 8'd1;
        end
        if (r_mem_we) r_addr <= r_addr + ADDR_W'(1);
      end
      r_cpu_run <= (w_state_nxt == DONE);
      r_busy    <= is_busy(w_state_nxt);
      r_err     <= (w_state_nxt == ERR);
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_run   = r_cpu_run;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: per-byte vector table plus timeout and reset sequences.
module tb_uart_loader;

  localparam int unsigned TB_TO = 12000;
  localparam int          GAP   = 20;
  localparam int          HOLD  = 3;
  localparam int          NVEC  = 28;

  typedef struct {
    logic [7:0] data;
    logic       we;
    logic [7:0] wd;
    logic [7:0] a1;
    logic [7:0] a2;
    logic       run;
    logic       busy;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_run;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_wr     = 0;
  vec_t tbl [NVEC];

  uart_loader #(
    .ADDR_W (8),
    .SYNC   (8'hA5),
    .TIMEOUT(TB_TO)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_run  (cpu_run),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we === 1'b1) n_wr++;

  initial begin
    #900_000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic we, input logic [7:0] wd,
                              input logic [7:0] a1, input logic [7:0] a2,
                              input logic run, input logic bsy, input logic er);
    vec_t v;
    v.data = d; v.we = we; v.wd = wd; v.a1 = a1; v.a2 = a2;
    v.run = run; v.busy = bsy; v.err = er;
    return v;
  endfunction

  // One byte: raise ready, check at n+1 and n+2, hold, drop, idle gap
  task automatic apply(input vec_t v, input int hold, input string tag);
    @(negedge clk);
    rx_data  = v.data;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " n+1"},
          32'({mem_we, mem_addr, (v.we ? mem_wdata : 8'h00), cpu_run, busy, err}),
          32'({v.we, v.a1, (v.we ? v.wd : 8'h00), v.run, v.busy, v.err}));
    @(posedge clk); #1;
    check({tag, " n+2"}, 32'({mem_we, mem_addr}), 32'({1'b0, v.a2}));
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (GAP) @(posedge clk);
  endtask

  initial begin
    int k;
    //              data   we  wd     a1     a2    run  busy err
    tbl[0]  = mk(8'h5A, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tbl[1]  = mk(8'hFF, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tbl[2]  = mk(8'hA5, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    tbl[3]  = mk(8'h03, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    tbl[4]  = mk(8'h11, 1, 8'h11, 8'h00, 8'h01, 0, 1, 0);
    tbl[5]  = mk(8'h22, 1, 8'h22, 8'h01, 8'h02, 0, 1, 0);
    tbl[6]  = mk(8'h33, 1, 8'h33, 8'h02, 8'h03, 0, 1, 0);
    tbl[7]  = mk(8'h66, 0, 8'h00, 8'h03, 8'h03, 1, 0, 0);
    tbl[8]  = mk(8'hA5, 0, 8'h00, 8'h03, 8'h03, 0, 1, 0);
    tbl[9]  = mk(8'h02, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    tbl[10] = mk(8'h10, 1, 8'h10, 8'h00, 8'h01, 0, 1, 0);
    tbl[11] = mk(8'h20, 1, 8'h20, 8'h01, 8'h02, 0, 1, 0);
    tbl[12] = mk(8'h31, 0, 8'h00, 8'h02, 8'h02, 0, 0, 1);
    tbl[13] = mk(8'hA5, 0, 8'h00, 8'h02, 8'h02, 0, 1, 0);
    tbl[14] = mk(8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    tbl[15] = mk(8'h00, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    tbl[16] = mk(8'hA5, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    tbl[17] = mk(8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    tbl[18] = mk(8'h00, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    tbl[19] = mk(8'hA5, 0, 8'h00, 8'h03, 8'h03, 0, 1, 0);
    tbl[20] = mk(8'h04, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    tbl[21] = mk(8'hA5, 0, 8'h00, 8'h01, 8'h01, 0, 1, 0);
    tbl[22] = mk(8'h02, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    tbl[23] = mk(8'h01, 1, 8'h01, 8'h00, 8'h01, 0, 1, 0);
    tbl[24] = mk(8'hA5, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    tbl[25] = mk(8'h01, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    tbl[26] = mk(8'h7E, 1, 8'h7E, 8'h00, 8'h01, 0, 1, 0);
    tbl[27] = mk(8'h7E, 0, 8'h00, 8'h01, 8'h01, 1, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 32'({mem_we, mem_addr, mem_wdata, cpu_run, busy, err}), 32'h0);
    @(negedge clk);
    clr = 1'b1;
    repeat (GAP) @(posedge clk);

    // Noise, good load, bad checksum, recovery, zero length
    for (int i = 0; i <= 18; i++) apply(tbl[i], HOLD, $sformatf("row%0d", i));
    check("writes after table", 32'(n_wr), 32'd5);

    // Good load again with rx_ready held for 5000 cycles per byte
    for (int i = 2; i <= 7; i++) apply(tbl[i], 5000, $sformatf("long row%0d", i));
    check("writes after long ready", 32'(n_wr), 32'd8);

    // Timeout: A5, 04, 01 then silence
    apply(tbl[19], HOLD, "row19");
    apply(tbl[20], HOLD, "row20");
    @(negedge clk);
    rx_data  = 8'h01;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    check("timeout write", 32'({mem_we, mem_addr, mem_wdata, busy, err}),
          32'({1'b1, 8'h00, 8'h01, 1'b1, 1'b0}));
    k = 0;
    for (int c = 1; c <= int'(TB_TO) + 50; c++) begin
      @(posedge clk); #1;
      if (err === 1'b1) begin
        k = c;
        break;
      end
    end
    check("timeout latency", 32'(k), 32'(TB_TO + 1));
    check("timeout state", 32'({err, busy, cpu_run, mem_addr}), 32'({1'b1, 1'b0, 1'b0, 8'h01}));
    check("writes after timeout", 32'(n_wr), 32'd9);
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (GAP) @(posedge clk);

    // Reset mid-packet, then a fresh one-byte load
    for (int i = 21; i <= 23; i++) apply(tbl[i], HOLD, $sformatf("row%0d", i));
    @(negedge clk);
    clr = 1'b0;
    #2;
    check("mid-packet reset", 32'({mem_we, mem_addr, mem_wdata, cpu_run, busy, err}), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    repeat (GAP) @(posedge clk);
    for (int i = 24; i <= 27; i++) apply(tbl[i], HOLD, $sformatf("row%0d", i));
    check("writes after reload", 32'(n_wr), 32'd11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
